div16x8_seq: RTL and testbench

DIV16X8_SEQ -- requirements
Module: div16x8_seq

---
 rtl/div16x8_seq.sv | 154 +++++++++++++++
 tb/tb_div16x8_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div16x8_seq.sv
// rtl/div16x8_seq.sv - 16-bit by 8-bit sequential restoring divider
//
// Purpose: divides a 16-bit dividend by an 8-bit divisor, one quotient bit
// per clock, producing a = q*b + rem with rem < b. A zero divisor
// completes in a single cycle with q=16'hFFFF, rem=a[7:0] and dz set.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   operation request, taken when busy=0
//   a      in  16   dividend, captured when start is taken
//   b      in   8   divisor, captured when start is taken
//   q      out 16   quotient (valid at done, held afterwards)
//   rem    out  8   remainder (valid at done, held afterwards)
//   busy   out  1   iteration in progress
//   done   out  1   one-cycle result-valid pulse
//   dz     out  1   last result was a divide by zero

module div16x8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [15:0] q,
    output logic [7:0]  rem,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [8:0]  prem_q,  prem_d;
    logic [15:0] dvd_q,   dvd_d;
    logic [7:0]  dvs_q,   dvs_d;
    logic [15:0] q_q,     q_d;
    logic [7:0]  rem_q,   rem_d;
    logic        dz_q,    dz_d;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // The partial remainder is always below the divisor, so its top bit
    // is zero going into a step and only the low eight bits are shifted.
    logic [8:0]  shifted;
    logic [9:0]  trial;
    logic        fits;
    logic [8:0]  prem_next;
    logic        unused_prem_msb;

    assign shifted         = {prem_q[7:0], dvd_q[15]};
    assign trial           = {1'b0, shifted} - {2'b00, dvs_q};
    assign fits            = ~trial[9];
    assign prem_next       = fits ? trial[8:0] : shifted;
    assign unused_prem_msb = prem_q[8];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            prem_q  <= 9'd0;
            dvd_q   <= 16'd0;
            dvs_q   <= 8'd0;
            q_q     <= 16'd0;
            rem_q   <= 8'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (b != 8'd0) ? S_RUN : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; q doubles as the quotient shift register
    always_comb begin
        cnt_d  = cnt_q;
        prem_d = prem_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        q_d    = q_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (b != 8'd0) begin
                        dvd_d  = a;
                        dvs_d  = b;
                        cnt_d  = 4'd0;
                        prem_d = 9'd0;
                        dz_d   = 1'b0;
                    end else begin
                        q_d    = 16'hFFFF;
                        rem_d  = a[7:0];
                        dz_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                prem_d = prem_next;
                dvd_d  = {dvd_q[14:0], 1'b0};
                q_d    = {q_q[14:0], fits};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    rem_d = prem_next[7:0];
                end
            end
            default: begin
                cnt_d = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from registers only
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        q    = q_q;
        rem  = rem_q;
        dz   = dz_q;
    end

endmodule

// File: tb/tb_div16x8_seq.sv
// tb/tb_div16x8_seq.sv - self-checking bench for div16x8_seq

module tb_div16x8_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  rem;
    logic        busy;
    logic        done;
    logic        dz;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    div16x8_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic quotient/remainder, fixed zero-divisor result
    function automatic void model(input logic [15:0] av, input logic [7:0] bv,
                                  output logic [15:0] eq, output logic [7:0] er,
                                  output logic ez);
        if (bv == 8'd0) begin
            eq = 16'hFFFF;
            er = av[7:0];
            ez = 1'b1;
        end else begin
            eq = av / {8'd0, bv};
            er = 8'(av % {8'd0, bv});
            ez = 1'b0;
        end
    endfunction

    // One isolated operation; operands are scrambled while it runs
    task automatic do_op(input logic [15:0] av, input logic [7:0] bv, input string tag);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int lat;
        int busy_cnt;
        model(av, bv, eq, er, ez);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'($urandom);
        b = 8'($urandom);
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, 32'(lat), (bv == 8'd0) ? 32'd1 : 32'd17);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), (bv == 8'd0) ? 32'd0 : 32'd16);
        check({tag, "_q"}, 32'(q), 32'(eq));
        check({tag, "_rem"}, 32'(rem), 32'(er));
        check({tag, "_dz"}, 32'(dz), 32'(ez));
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_q_hold"}, 32'({q, rem}), 32'({eq, er}));
    endtask

    initial begin
        logic [15:0] hav [3];
        logic [7:0]  hbv [3];
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int edges;
        int seen_done;
        int last_done_cyc;

        rst_n = 1'b0;
        start = 1'b1;
        a = 16'h5555;
        b = 8'h11;
        tick();
        tick();
        check("reset_q", 32'(q), 32'd0);
        check("reset_rem", 32'(rem), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dz", 32'(dz), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        do_op(16'h3039, 8'h64, "basic_12345_100");
        check("basic_q_const", 32'(q), 32'h007B);
        check("basic_rem_const", 32'(rem), 32'h2D);

        do_op(16'hFFFF, 8'h01, "ffff_div_1");
        do_op(16'hFFFF, 8'hFF, "ffff_div_ff");
        check("ffff_div_ff_const", 32'(q), 32'h0101);
        do_op(16'h0000, 8'h07, "zero_div_7");

        do_op(16'h1234, 8'h00, "div_by_zero");
        check("div_by_zero_rem_const", 32'(rem), 32'h34);
        do_op(16'd10, 8'd3, "after_dz");
        check("after_dz_clear", 32'(dz), 32'd0);

        // Start pulse while busy must be ignored
        a = 16'd100;
        b = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        repeat (4) begin
            tick();
            edges++;
        end
        a = 16'd9;
        b = 8'd9;
        start = 1'b1;
        tick();
        edges++;
        start = 1'b0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check("busy_start_latency", 32'(edges), 32'd17);
        check("busy_start_q", 32'(q), 32'd14);
        check("busy_start_rem", 32'(rem), 32'd2);
        tick();

        // Reset in the middle of a run: outputs cleared, no done pulse
        a = 16'd1000;
        b = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_reset_q", 32'(q), 32'd0);
        check("midrun_reset_rem", 32'(rem), 32'd0);
        check("midrun_reset_busy", 32'(busy), 32'd0);
        check("midrun_reset_done", 32'(done), 32'd0);
        check("midrun_reset_dz", 32'(dz), 32'd0);
        seen_done = 0;
        repeat (20) begin
            tick();
            if (done || busy) seen_done++;
        end
        check("midrun_reset_no_done", 32'(seen_done), 32'd0);
        do_op(16'd1000, 8'd10, "after_reset");

        // start held high: back-to-back operations every 17 cycles
        hav[0] = 16'd5000;  hbv[0] = 8'd77;
        hav[1] = 16'd65535; hbv[1] = 8'd3;
        hav[2] = 16'd42;    hbv[2] = 8'd200;
        a = hav[0];
        b = hbv[0];
        start = 1'b1;
        tick();
        last_done_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            edges = 0;
            while (!done && edges < 40) begin
                tick();
                edges++;
            end
            model(hav[k], hbv[k], eq, er, ez);
            check($sformatf("held%0d_wait", k), 32'(edges), 32'd16);
            check($sformatf("held%0d_q", k), 32'(q), 32'(eq));
            check($sformatf("held%0d_rem", k), 32'(rem), 32'(er));
            check($sformatf("held%0d_dz", k), 32'(dz), 32'(ez));
            if (k > 0) check($sformatf("held%0d_spacing", k), 32'(cyc - last_done_cyc), 32'd17);
            last_done_cyc = cyc;
            if (k < 2) begin
                a = hav[k + 1];
                b = hbv[k + 1];
                tick();
                check($sformatf("held%0d_reaccept_busy", k), 32'(busy), 32'd1);
                check($sformatf("held%0d_reaccept_done", k), 32'(done), 32'd0);
            end else begin
                start = 1'b0;
                tick();
                check("held_end_done", 32'(done), 32'd0);
                check("held_end_busy", 32'(busy), 32'd0);
            end
        end

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 1500; i++) begin
            do_op(16'($urandom), 8'($urandom_range(1, 255)), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
